// File: rtl/nonogram_pkg.sv
// Shared constants, state encoding and sizing helper for the solution serializer.
package nonogram_pkg;

    localparam int         MAX_ROWS_DEF = 16;
    localparam int         MAX_COLS_DEF = 16;
    localparam logic [7:0] HEADER_DEF   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ROWS,
        COLS,
        PAYLOAD,
        CHK
    } ser_state_t;

    // Number of payload bytes needed to carry one row of 'cols' cells.
    function automatic int bytes_per_row(input int cols);
        return (cols + 7) / 8;
    endfunction

endpackage

// File: rtl/row_byte_mux.sv
// Selects byte 'byte_idx' of one board row and clears bits beyond the board width.
module row_byte_mux #(
    parameter int MAX_COLS = 16,
    parameter int DIM_W    = 5,
    parameter int BI_W     = 1
) (
    input  logic [MAX_COLS-1:0] row,
    input  logic [BI_W-1:0]     byte_idx,
    input  logic [DIM_W-1:0]    cols,
    output logic [7:0]          slice
);

    // Gather columns 8*byte_idx .. 8*byte_idx+7, LSB = lowest column, masked at cols.
    always_comb begin
        // NOTE: default assignment first so every path drives slice and no latch is inferred.
        slice = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            if ((c / 8) == int'(byte_idx) && c < int'(cols)) begin
                slice[c % 8] = row[c];
            end
        end
    end

endmodule

// File: rtl/solution_serializer.sv
// Snapshots a solved board and streams it as HEADER, rows, cols, payload, XOR checksum.
module solution_serializer
    import nonogram_pkg::*;
#(
    parameter int         MAX_ROWS = MAX_ROWS_DEF,
    parameter int         MAX_COLS = MAX_COLS_DEF,
    parameter logic [7:0] HEADER   = HEADER_DEF,
    parameter int         DIM_W    = $clog2((MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_in,
    input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  solution,
    input  logic [DIM_W-1:0]                   num_rows,
    input  logic [DIM_W-1:0]                   num_cols,
    input  logic                               byte_ready,
    output logic                               byte_valid,
    output logic [7:0]                         byte_out,
    output logic                               busy,
    output logic                               frame_done,
    output logic                               dim_error,
    output logic                               overrun
);

    localparam int BPR_MAX = bytes_per_row(MAX_COLS);
    localparam int BI_W    = (BPR_MAX > 1) ? $clog2(BPR_MAX) : 1;
    localparam int RI_W    = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

    ser_state_t                        state;
    ser_state_t                        next_state;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0] snap_q;
    logic [DIM_W-1:0]                  rows_q;
    logic [DIM_W-1:0]                  cols_q;
    logic [BI_W-1:0]                   last_byte_q;
    logic                              dims_ok_q;
    logic [RI_W-1:0]                   row_idx;
    logic [BI_W-1:0]                   byte_idx;
    logic [7:0]                        chk_q;
    logic [7:0]                        payload_byte;
    logic                              accept;
    logic                              transfer;
    logic                              last_byte;
    logic                              last_row;
    logic                              req_ok;

    assign accept    = valid_in && (state == IDLE);
    assign transfer  = byte_valid && byte_ready;
    assign busy      = (state != IDLE);
    assign last_byte = (byte_idx == last_byte_q);
    assign last_row  = (int'(row_idx) == int'(rows_q) - 1);
    assign req_ok    = (num_rows != '0) && (num_cols != '0) &&
                       (int'(num_rows) <= MAX_ROWS) && (int'(num_cols) <= MAX_COLS);

    row_byte_mux #(
        .MAX_COLS (MAX_COLS),
        .DIM_W    (DIM_W),
        .BI_W     (BI_W)
    ) u_row_byte_mux (
        .row      (snap_q[row_idx]),
        .byte_idx (byte_idx),
        .cols     (cols_q),
        .slice    (payload_byte)
    );

    // Capture the board and its geometry when a request is accepted.
    always_ff @(posedge clk) begin
        // NOTE: the snapshot is pure data qualified by the FSM, so it carries no reset.
        if (accept) begin
            snap_q      <= solution;
            rows_q      <= num_rows;
            cols_q      <= num_cols;
            dims_ok_q   <= req_ok;
            last_byte_q <= BI_W'(bytes_per_row(int'(num_cols)) - 1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and frame byte selection; byte_out only changes when the state or counters move.
    always_comb begin
        next_state = state;
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        unique case (state)
            IDLE: begin
                if (valid_in) next_state = HDR;
            end
            HDR: begin
                byte_valid = 1'b1;
                byte_out   = HEADER;
                if (byte_ready) next_state = ROWS;
            end
            ROWS: begin
                byte_valid = 1'b1;
                byte_out   = dims_ok_q ? 8'(rows_q) : 8'h00;
                if (byte_ready) next_state = COLS;
            end
            COLS: begin
                byte_valid = 1'b1;
                byte_out   = dims_ok_q ? 8'(cols_q) : 8'h00;
                if (byte_ready) next_state = dims_ok_q ? PAYLOAD : CHK;
            end
            PAYLOAD: begin
                byte_valid = 1'b1;
                byte_out   = payload_byte;
                if (byte_ready && last_byte && last_row) next_state = CHK;
            end
            CHK: begin
                byte_valid = 1'b1;
                byte_out   = chk_q;
                if (byte_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters, running checksum and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            dim_error  <= 1'b0;
            overrun    <= 1'b0;
            chk_q      <= '0;
            row_idx    <= '0;
            byte_idx   <= '0;
        end else begin
            frame_done <= (state == CHK) && transfer;
            if (valid_in && state != IDLE) overrun <= 1'b1;
            if (accept) begin
                dim_error <= !req_ok;
                chk_q     <= '0;
                row_idx   <= '0;
                byte_idx  <= '0;
            end else if (transfer) begin
                chk_q <= chk_q ^ byte_out;
                if (state == PAYLOAD) begin
                    if (last_byte) begin
                        byte_idx <= '0;
                        if (!last_row) row_idx <= row_idx + RI_W'(1);
                    end else begin
                        byte_idx <= byte_idx + BI_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_solution_serializer.sv
// Directed, table-driven bench for solution_serializer with a small frame model.
module tb_solution_serializer;

    localparam int DIM_W = 5;

    typedef struct {
        int                 rows;
        int                 cols;
        logic [15:0][15:0]  grid;
        bit                 stall;
        int                 inject_at;
        logic [7:0]         exp_chk;
        int                 exp_len;
        bit                 exp_dim;
        bit                 exp_ovr;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_in;
    logic [15:0][15:0]       solution;
    logic [DIM_W-1:0]        num_rows;
    logic [DIM_W-1:0]        num_cols;
    logic                    byte_ready;
    logic                    byte_valid;
    logic [7:0]              byte_out;
    logic                    busy;
    logic                    frame_done;
    logic                    dim_error;
    logic                    overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    vec_t       vecs[8];

    solution_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .solution   (solution),
        .num_rows   (num_rows),
        .num_cols   (num_cols),
        .byte_ready (byte_ready),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .busy       (busy),
        .frame_done (frame_done),
        .dim_error  (dim_error),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, input int c, input logic [15:0][15:0] g,
                                input bit st, input int inj, input logic [7:0] chk,
                                input int len, input bit de, input bit ov);
        vec_t v;
        v.rows = r; v.cols = c; v.grid = g; v.stall = st; v.inject_at = inj;
        v.exp_chk = chk; v.exp_len = len; v.exp_dim = de; v.exp_ovr = ov;
        return v;
    endfunction

    // Reference frame: header, dims, masked row bytes, XOR of all preceding bytes.
    task automatic build_model(input vec_t v);
        logic [7:0] b;
        logic [7:0] chk;
        bit         ok;
        exp_q.delete();
        ok = v.rows >= 1 && v.cols >= 1 && v.rows <= 16 && v.cols <= 16;
        exp_q.push_back(8'hA5);
        exp_q.push_back(ok ? 8'(v.rows) : 8'h00);
        exp_q.push_back(ok ? 8'(v.cols) : 8'h00);
        if (ok) begin
            for (int r = 0; r < v.rows; r++) begin
                for (int k = 0; k < (v.cols + 7) / 8; k++) begin
                    b = 8'h00;
                    for (int bt = 0; bt < 8; bt++) begin
                        if (8 * k + bt < v.cols) b[bt] = v.grid[r][8 * k + bt];
                    end
                    exp_q.push_back(b);
                end
            end
        end
        chk = 8'h00;
        foreach (exp_q[i]) chk = chk ^ exp_q[i];
        exp_q.push_back(chk);
    endtask

    // Issue one request and receive the whole frame, checking every byte and the end-of-frame flags.
    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        int         cyc;
        bit         injected;
        bit         prev_stalled;
        logic [7:0] prev;
        logic [7:0] last_got;
        build_model(v);
        got_q.delete();
        @(negedge clk);
        byte_ready = 1'b0;
        valid_in   = 1'b1;
        num_rows   = DIM_W'(v.rows);
        num_cols   = DIM_W'(v.cols);
        solution   = v.grid;
        @(negedge clk);
        valid_in = 1'b0;
        check({tag, "_lat_valid"}, 32'(byte_valid), 32'd1);
        check({tag, "_lat_hdr"}, 32'(byte_out), 32'hA5);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0; cyc = 0; injected = 1'b0; prev_stalled = 1'b0; prev = 8'h00; last_got = 8'h00;
        while (n < v.exp_len && cyc < 400) begin
            byte_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            valid_in   = (n == v.inject_at) && !injected && byte_valid && byte_ready;
            if (valid_in) begin
                injected = 1'b1;
                num_rows = DIM_W'(1);
                num_cols = DIM_W'(1);
                solution = '1;
            end
            if (prev_stalled) check($sformatf("%s_hold%0d", tag, n), 32'(byte_out), 32'(prev));
            if (byte_valid && byte_ready) begin
                if (n < exp_q.size())
                    check($sformatf("%s_byte%0d", tag, n), 32'(byte_out), 32'(exp_q[n]));
                got_q.push_back(byte_out);
                last_got     = byte_out;
                prev_stalled = 1'b0;
                n++;
            end else begin
                prev_stalled = byte_valid;
                prev         = byte_out;
            end
            @(negedge clk);
            cyc++;
        end
        valid_in = 1'b0;
        check({tag, "_len"}, 32'(n), 32'(v.exp_len));
        check({tag, "_chk"}, 32'(last_got), 32'(v.exp_chk));
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        check({tag, "_end_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_dim_err"}, 32'(dim_error), 32'(v.exp_dim));
        check({tag, "_overrun"}, 32'(overrun), 32'(v.exp_ovr));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        check({tag, "_idle_valid"}, 32'(byte_valid), 32'd0);
    endtask

    initial begin
        logic [15:0][15:0] g;
        logic [7:0]        hand0[6];
        hand0 = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h02, 8'hA3};

        g = '0; g[0] = 16'h0005; g[1] = 16'h0002;
        vecs[0] = mk(2, 3, g, 1'b0, -1, 8'hA3, 6, 1'b0, 1'b0);
        vecs[6] = mk(2, 3, g, 1'b0, 2, 8'hA3, 6, 1'b0, 1'b1);
        g = '0; g[0] = 16'hFFFF;
        vecs[1] = mk(11, 11, g, 1'b0, -1, 8'h5D, 26, 1'b0, 1'b0);
        for (int r = 0; r < 16; r++) g[r] = 16'(r + 1);
        vecs[2] = mk(16, 16, g, 1'b1, -1, 8'hB5, 36, 1'b0, 1'b0);
        g = '1;
        vecs[3] = mk(0, 5, g, 1'b0, -1, 8'hA5, 4, 1'b1, 1'b0);
        vecs[4] = mk(1, 1, g, 1'b0, -1, 8'hA4, 5, 1'b0, 1'b0);
        vecs[5] = mk(3, 17, g, 1'b0, -1, 8'hA5, 4, 1'b1, 1'b0);
        g = '0; g[0] = 16'hFFFF; g[1] = 16'h0200; g[2] = 16'h0155;
        vecs[7] = mk(3, 9, g, 1'b0, 9, 8'h05, 10, 1'b0, 1'b1);

        rst = 1'b1; valid_in = 1'b0; byte_ready = 1'b0;
        solution = '0; num_rows = '0; num_cols = '0;
        repeat (3) @(negedge clk);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_dim_error", 32'(dim_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                check("v0_hand_len", 32'(got_q.size()), 32'd6);
                for (int j = 0; j < 6 && j < got_q.size(); j++)
                    check($sformatf("v0_hand%0d", j), 32'(got_q[j]), 32'(hand0[j]));
            end
        end

        // Request arriving mid-frame is dropped and the original frame continues.
        run_vec(vecs[6], "ovr_mid");

        // Reset during PAYLOAD aborts the frame and clears the sticky flags.
        @(negedge clk);
        byte_ready = 1'b1;
        valid_in   = 1'b1;
        num_rows   = DIM_W'(16);
        num_cols   = DIM_W'(16);
        solution   = vecs[2].grid;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(byte_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_byte_out", 32'(byte_out), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("abort_quiet", 32'(byte_valid), 32'd0);
        run_vec(vecs[0], "restart");

        // Request in the same cycle as the checksum transfer counts as overrun and is dropped.
        run_vec(vecs[7], "ovr_chk");
        repeat (3) @(negedge clk);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_no_frame", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
